seg_scan_reader: RTL and testbench

- Receive side of the team's 7-segment display path: samples a multiplexed, active-high segment bus (segments A–G, Dp, one-hot digit enable) as driven by our segment decoders and scan drivers.
- Recovers the hex nibble and decimal point shown on each digit, and publishes a complete frame with a one-cycle valid pulse.
- Used as a loopback checker in display datapaths and as a self-checking monitor on the lab boards.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_pattern_decode.sv | 23 ++
 rtl/seg_scan_reader.sv | 163 ++++++++++++++++
 tb/tb_seg_scan_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: segment bit order,
// the hex glyph table used by both encoders and readers, and scan FSM states.
package seg_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Glyph for nibble n lives at index n; bit k drives segment SEG_A+k.
    localparam logic [6:0] HEX_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_BLANK,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational glyph-to-nibble decoder; any pattern outside the hex table
// (including all-off) yields nibble 0 with err set.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        nibble = 4'h0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (pattern == HEX_PATTERN[i]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_reader.sv
// Receive side of the multiplexed 7-segment bus: debounces each digit dwell,
// decodes the glyph, and publishes a full frame with a one-cycle valid pulse.
module seg_scan_reader
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int STABLE  = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_in,
    input  logic                dp_in,
    input  logic [DIGITS-1:0]   dig_en,
    output logic [4*DIGITS-1:0] value,
    output logic [DIGITS-1:0]   dp_out,
    output logic [DIGITS-1:0]   err,
    output logic                frame_valid,
    output logic                stale
);

    localparam int CNT_W = $clog2(STABLE + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    // Current registered sample S and the sample before it.
    logic [6:0]        s_seg, p_seg;
    logic              s_dp, p_dp;
    logic [DIGITS-1:0] s_dig, p_dig;

    scan_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [TO_W-1:0]   to_cnt;

    logic [4*DIGITS-1:0] sh_value;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_err;
    logic [DIGITS-1:0]   seen;
    logic [DIGITS-1:0]   seen_next;

    logic       s_changed;
    logic       s_onehot;
    logic       capture;
    logic       frame_done;
    logic       timeout_hit;
    logic [3:0] dec_nibble;
    logic       dec_err;

    seg_pattern_decode u_decode (
        .pattern (s_seg),
        .nibble  (dec_nibble),
        .err     (dec_err)
    );

    assign s_changed   = (s_seg != p_seg) || (s_dp != p_dp) || (s_dig != p_dig);
    assign s_onehot    = $onehot(s_dig);
    assign capture     = (state == ST_SETTLE) && !s_changed
                         && (cnt == CNT_W'(STABLE - 1));
    assign frame_done  = &seen;
    assign timeout_hit = !capture && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_seg <= '0;
            s_dp  <= 1'b0;
            s_dig <= '0;
            p_seg <= '0;
            p_dp  <= 1'b0;
            p_dig <= '0;
        end else begin
            s_seg <= seg_in;
            s_dp  <= dp_in;
            s_dig <= dig_en;
            p_seg <= s_seg;
            p_dp  <= s_dp;
            p_dig <= s_dig;
        end
    end

    // Dwell tracker: a new sample restarts the run; capture fires once per dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BLANK;
            cnt   <= '0;
        end else if (s_changed) begin
            if (s_onehot) begin
                state <= ST_SETTLE;
                cnt   <= CNT_W'(1);
            end else begin
                state <= ST_BLANK;
                cnt   <= '0;
            end
        end else begin
            case (state)
                ST_SETTLE: begin
                    if (capture) begin
                        state <= ST_HELD;
                        cnt   <= CNT_W'(STABLE);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seen_next = seen;
        if (frame_done || timeout_hit) seen_next = '0;
        if (capture) seen_next = seen_next | s_dig;
    end

    // NOTE: the shadow is a handful of flops, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_value <= '0;
            sh_dp    <= '0;
            sh_err   <= '0;
            seen     <= '0;
        end else begin
            seen <= seen_next;
            for (int i = 0; i < DIGITS; i++) begin
                if (capture && s_dig[i]) begin
                    sh_value[4*i +: 4] <= dec_nibble;
                    sh_dp[i]           <= s_dp;
                    sh_err[i]          <= dec_err;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (capture) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TIMEOUT)) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Frame completion takes priority over a coincident timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            dp_out      <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            stale       <= 1'b1;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                value  <= sh_value;
                dp_out <= sh_dp;
                err    <= sh_err;
                stale  <= 1'b0;
            end else if (timeout_hit) begin
                stale <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: frame table, hand-written corner
// sequences and random scanning, all compared against a run-length model.
module tb_seg_scan_reader;

    localparam int DIGITS  = 4;
    localparam int STABLE  = 3;
    localparam int TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg_in = '0;
    logic        dp_in = 1'b0;
    logic [3:0]  dig_en = '0;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  err;
    logic        frame_valid;
    logic        stale;

    always #5 clk = ~clk;

    seg_scan_reader #(
        .DIGITS  (DIGITS),
        .STABLE  (STABLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .dig_en      (dig_en),
        .value       (value),
        .dp_out      (dp_out),
        .err         (err),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
    } pins_t;

    typedef struct {
        logic [27:0] pats;
        logic [3:0]  dps;
        logic [15:0] exp_val;
        logic [3:0]  exp_dp;
        logic [3:0]  exp_err;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] hex_tab [16];

    // Reference model: decisions come from the run length of each registered sample.
    pins_t       q_pins, prev_sample;
    int          run;
    int          m_idle;
    bit          m_pending;
    logic [15:0] m_sh_val, m_val;
    logic [3:0]  m_sh_dp, m_sh_err, m_mask, m_dpo, m_erro;
    logic        m_fv, m_stale;

    int          pulses;
    logic [15:0] last_val;
    logic [3:0]  last_dp, last_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void decode(input logic [6:0] p, output logic [3:0] n, output logic e);
        n = 4'h0;
        e = 1'b1;
        for (int i = 0; i < 16; i++)
            if (p == hex_tab[i]) begin
                n = 4'(i);
                e = 1'b0;
            end
    endfunction

    function automatic void model_reset();
        q_pins = '0; prev_sample = '0; run = 0; m_idle = 0; m_pending = 0;
        m_sh_val = '0; m_sh_dp = '0; m_sh_err = '0; m_mask = '0;
        m_val = '0; m_dpo = '0; m_erro = '0; m_fv = 0; m_stale = 1;
    endfunction

    // One clock edge; s is the sample that was registered on the previous edge.
    function automatic void model_edge(input pins_t s);
        bit         cap, published;
        logic [3:0] n;
        logic       e;
        if (s == prev_sample) run++;
        else run = 1;
        prev_sample = s;
        cap = (run == STABLE) && $onehot(s.dig);
        m_fv = 0;
        published = 0;
        if (m_pending) begin
            m_val = m_sh_val; m_dpo = m_sh_dp; m_erro = m_sh_err;
            m_fv = 1; m_stale = 0; m_mask = '0; m_pending = 0;
            published = 1;
        end
        if (cap) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle == TIMEOUT && !published) begin
                m_stale = 1;
                m_mask  = '0;
            end
        end
        if (cap) begin
            decode(s.seg, n, e);
            for (int d = 0; d < DIGITS; d++)
                if (s.dig[d]) begin
                    m_sh_val[4*d +: 4] = n;
                    m_sh_dp[d]  = s.dp;
                    m_sh_err[d] = e;
                    m_mask[d]   = 1'b1;
                end
            if (&m_mask) m_pending = 1;
        end
    endfunction

    // Called at a falling edge: drive pins, advance one clock, compare.
    task automatic cycle(input pins_t p);
        seg_in = p.seg; dp_in = p.dp; dig_en = p.dig;
        @(posedge clk);
        model_edge(q_pins);
        q_pins = p;
        @(negedge clk);
        check("cycle", {6'b0, value, dp_out, err, frame_valid, stale},
              {6'b0, m_val, m_dpo, m_erro, m_fv, m_stale});
        if (frame_valid) begin
            pulses++;
            last_val = value; last_dp = dp_out; last_err = err;
        end
    endtask

    task automatic dwell(input logic [6:0] seg, input logic dp, input logic [3:0] dig, input int n);
        pins_t p;
        p.seg = seg; p.dp = dp; p.dig = dig;
        repeat (n) cycle(p);
    endtask

    task automatic scan(input logic [27:0] pats, input logic [3:0] dps, input int n);
        for (int d = 0; d < DIGITS; d++) dwell(pats[7*d +: 7], dps[d], 4'(1 << d), n);
    endtask

    task automatic do_reset();
        seg_in = '0; dp_in = 1'b0; dig_en = '0;
        rst_n = 1'b0;
        #1;
        check("reset_outputs", {6'b0, value, dp_out, err, frame_valid, stale}, 32'h1);
        repeat (3) @(negedge clk);
        model_reset();
        pulses = 0;
        rst_n = 1'b1;
    endtask

    task automatic check_frame(input string name, input int exp_pulses, input logic [15:0] v,
                               input logic [3:0] d, input logic [3:0] e);
        check({name, "_pulses"}, pulses, exp_pulses);
        check({name, "_value"}, {16'b0, last_val}, {16'b0, v});
        check({name, "_dp"}, {28'b0, last_dp}, {28'b0, d});
        check({name, "_err"}, {28'b0, last_err}, {28'b0, e});
        check({name, "_stale"}, {31'b0, stale}, 32'h0);
    endtask

    vec_t vecs [6];

    initial begin
        hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        // pats = {digit3, digit2, digit1, digit0}
        vecs[0] = '{{7'h3F, 7'h06, 7'h5B, 7'h4F}, 4'b0000, 16'h0123, 4'b0000, 4'b0000};
        vecs[1] = '{{7'h71, 7'h7C, 7'h71, 7'h71}, 4'b0100, 16'hFBFF, 4'b0100, 4'b0000};
        vecs[2] = '{{7'h3F, 7'h06, 7'h49, 7'h4F}, 4'b0000, 16'h0103, 4'b0000, 4'b0010};
        vecs[3] = '{{7'h7F, 7'h07, 7'h7D, 7'h6D}, 4'b1001, 16'h8765, 4'b1001, 4'b0000};
        vecs[4] = '{{7'h5E, 7'h39, 7'h77, 7'h6F}, 4'b0110, 16'hDCA9, 4'b0110, 4'b0000};
        vecs[5] = '{{7'h3F, 7'h00, 7'h66, 7'h79}, 4'b0000, 16'h004E, 4'b0000, 4'b0100};

        model_reset();
        pulses = 0; last_val = '0; last_dp = '0; last_err = '0;
        #2;
        do_reset();

        for (int i = 0; i < 6; i++) begin
            pulses = 0;
            scan(vecs[i].pats, vecs[i].dps, 8);
            check_frame($sformatf("vec%0d", i), 1, vecs[i].exp_val, vecs[i].exp_dp, vecs[i].exp_err);
        end

        // Short 7F glitches on digit 0 showing 3F, before and after its capture.
        pulses = 0;
        dwell(7'h3F, 1'b0, 4'b0001, 2);
        dwell(7'h7F, 1'b0, 4'b0001, 2);
        dwell(7'h3F, 1'b0, 4'b0001, 6);
        dwell(7'h7F, 1'b0, 4'b0001, 2);
        dwell(7'h3F, 1'b0, 4'b0001, 4);
        dwell(7'h06, 1'b0, 4'b0010, 8);
        dwell(7'h5B, 1'b0, 4'b0100, 8);
        dwell(7'h4F, 1'b0, 4'b1000, 8);
        check_frame("glitch", 1, 16'h3210, 4'b0000, 4'b0000);

        // Two digits enabled at once must never be captured.
        pulses = 0;
        dwell(7'h4F, 1'b0, 4'b0001, 8);
        dwell(7'h5B, 1'b0, 4'b0010, 8);
        dwell(7'h7F, 1'b1, 4'b0011, 10);
        check("multi_en_no_pulse", pulses, 0);
        dwell(7'h06, 1'b0, 4'b0100, 8);
        dwell(7'h3F, 1'b0, 4'b1000, 8);
        check_frame("multi_en", 1, 16'h0123, 4'b0000, 4'b0000);

        // Scanning stops: stale rises, value is held, next frame recovers.
        dwell(7'h00, 1'b0, 4'b0000, TIMEOUT + 10);
        check("timeout_stale", {31'b0, stale}, 32'h1);
        check("timeout_hold", {16'b0, value}, 32'h0123);
        pulses = 0;
        scan(vecs[1].pats, vecs[1].dps, 8);
        check_frame("after_timeout", 1, 16'hFBFF, 4'b0100, 4'b0000);

        // Reset mid-frame, then a clean frame.
        pulses = 0;
        for (int d = 0; d < 3; d++) dwell(vecs[3].pats[7*d +: 7], vecs[3].dps[d], 4'(1 << d), 8);
        check("partial_no_pulse", pulses, 0);
        do_reset();
        last_val = '0; last_dp = '0; last_err = '0;
        scan(vecs[3].pats, vecs[3].dps, 8);
        check_frame("after_reset", 1, 16'h8765, 4'b1001, 4'b0000);

        // Random scanning against the model.
        for (int k = 0; k < 400; k++) begin
            logic [6:0] s;
            logic [3:0] g;
            if ($urandom_range(0, 9) < 8) s = hex_tab[$urandom_range(0, 15)];
            else s = 7'($urandom);
            if ($urandom_range(0, 9) < 7) g = 4'(1 << $urandom_range(0, 3));
            else g = 4'($urandom);
            dwell(s, 1'($urandom), g, $urandom_range(1, 7));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
